// File: rtl/matvec_dot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matvec_dot_scheduler
// Purpose  : Computes Y = M*x by feeding one row at a time, together with the
//            vector, into a single shared sequential dot-product engine, and
//            collecting each scalar result into a packed output vector.
// Revision : 1.0 - initial release
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   job request, sampled only while idle
//   matrix     in   ROWS rows of VLEN fp32 elements; row r at [32*VLEN*r +: 32*VLEN]
//   vector     in   VLEN fp32 elements, operand x
//   busy       out  job in progress
//   done       out  job complete, held until the next accepted start or reset
//   error      out  per-row watchdog fired (always 0 unless MVS_TIMEOUT_EN)
//   result     out  y[r] at [32*r +: 32]
//   row_idx    out  row currently in flight
//   dp_A       out  engine operand A (current row), registered
//   dp_B       out  engine operand B (vector), registered
//   dp_result  in   engine scalar result
//   dp_done    in   engine completion flag; drops on any operand change
//
// Build option
//   MVS_TIMEOUT_EN : adds a per-row cycle watchdog of TIMEOUT cycles. When it
//                    expires, error is raised, the remaining rows are dropped
//                    and the job finishes with done asserted.
// ============================================================================
module matvec_dot_scheduler #(
  parameter int VLEN    = 4,
  parameter int ROWS    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [32*ROWS*VLEN-1:0]   matrix,
  input  logic [32*VLEN-1:0]        vector,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [32*ROWS-1:0]        result,
  output logic [$clog2(ROWS):0]     row_idx,
  output logic [32*VLEN-1:0]        dp_A,
  output logic [32*VLEN-1:0]        dp_B,
  input  logic [31:0]               dp_result,
  input  logic                      dp_done
);

  localparam int AW = 32 * VLEN;
  localparam int RW = $clog2(ROWS) + 1;
  // Index width for selecting one of ROWS rows (at least one bit).
  localparam int SW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_STORE     = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t                   state_q;
  logic [ROWS-1:0][AW-1:0]  mat_q;
  logic [AW-1:0]            vec_q;
  logic [ROWS-1:0][31:0]    result_q;
  logic [RW-1:0]            row_idx_q;
  logic [AW-1:0]            dp_a_q;
  logic [AW-1:0]            dp_b_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     error_q;
  logic                     dp_valid_q;   // dp_result belongs to dp_a_q/dp_b_q
  logic                     seen_low_q;   // dp_done has dropped for current operands

  logic [SW-1:0]            row_sel_d;
  logic [AW-1:0]            new_a_d;
  logic                     dup_d;
  logic                     tmo_hit_d;

  assign row_sel_d = row_idx_q[SW-1:0];
  assign new_a_d   = mat_q[row_sel_d];

  // When the engine already holds exactly these operands its done flag will
  // never drop, so waiting for it would hang; reuse the held result instead.
  assign dup_d = dp_valid_q && (new_a_d == dp_a_q) && (vec_q == dp_b_q);

`ifdef MVS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] tmo_cnt_q;

  // Counts wait cycles of the current row; the wait state that sees
  // TIMEOUT-1 is the TIMEOUT-th and aborts the job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_LOAD) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_WAIT_CLR || state_q == S_WAIT_DONE) begin
      tmo_cnt_q <= tmo_cnt_q + CW'(1);
    end
  end

  assign tmo_hit_d = (tmo_cnt_q == TMO_LAST);
  assign error     = error_q;
`else
  assign tmo_hit_d = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mat_q      <= '0;
      vec_q      <= '0;
      result_q   <= '0;
      row_idx_q  <= '0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      dp_valid_q <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mat_q     <= matrix;
            vec_q     <= vector;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            result_q  <= '0;
            row_idx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end

        S_LOAD: begin
          dp_b_q <= vec_q;
          if (dup_d) begin
            state_q <= S_STORE;
          end else begin
            dp_a_q     <= new_a_d;
            // The held result no longer matches the operands until this
            // row completes; matters if the row is abandoned by the watchdog.
            dp_valid_q <= 1'b0;
            seen_low_q <= 1'b0;
            state_q    <= S_WAIT_CLR;
          end
        end

        S_WAIT_CLR: begin
          // dp_done high here is left over from the previous operands.
          if (tmo_hit_d) begin
            error_q <= 1'b1;
            state_q <= S_FINISH;
          end else if (!dp_done) begin
            seen_low_q <= 1'b1;
            state_q    <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (tmo_hit_d) begin
            error_q <= 1'b1;
            state_q <= S_FINISH;
          end else if (dp_done && seen_low_q) begin
            state_q <= S_STORE;
          end
        end

        S_STORE: begin
          result_q[row_sel_d] <= dp_result;
          dp_valid_q          <= 1'b1;
          if (row_idx_q == LAST_ROW) begin
            state_q <= S_FINISH;
          end else begin
            row_idx_q <= row_idx_q + RW'(1);
            state_q   <= S_LOAD;
          end
        end

        S_FINISH: begin
          // dp_A/dp_B are left untouched so the engine stays idle-done.
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign row_idx = row_idx_q;
  assign dp_A    = dp_a_q;
  assign dp_B    = dp_b_q;

endmodule
`default_nettype wire

// File: tb/tb_matvec_dot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_matvec_dot_scheduler
// Purpose  : Scoreboard bench for matvec_dot_scheduler (ROWS=2, VLEN=2)
//            driving directed jobs against a behavioural dot-product engine
//            whose done flag drops on operand change and returns 3 cycles
//            later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matvec_dot_scheduler;

  localparam int VLEN = 2;
  localparam int ROWS = 2;
  localparam int TMO  = 16;
  localparam int MW   = 32 * ROWS * VLEN;
  localparam int VW   = 32 * VLEN;
  localparam int YW   = 32 * ROWS;
  localparam int RW   = $clog2(ROWS) + 1;

  localparam logic [31:0] F1 = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2 = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3 = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F4 = 32'h4080_0000;  // 4.0
  localparam logic [31:0] F7 = 32'h40E0_0000;  // 7.0

  // M1 = [[1,2],[3,4]], M2 = [[2,2],[2,2]], M3 = [[3,4],[1,2]], x = [1,1]
  localparam logic [MW-1:0] M1 = {F4, F3, F2, F1};
  localparam logic [MW-1:0] M2 = {F2, F2, F2, F2};
  localparam logic [MW-1:0] M3 = {F2, F1, F4, F3};
  localparam logic [VW-1:0] X1 = {F1, F1};
  localparam logic [YW-1:0] Y1 = {F7, F3};
  localparam logic [YW-1:0] Y2 = {F4, F4};
  localparam logic [YW-1:0] Y3 = {F3, F7};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] matrix;
  logic [VW-1:0] vector;
  logic          busy, done, error;
  logic [YW-1:0] result;
  logic [RW-1:0] row_idx;
  logic [VW-1:0] dp_A, dp_B;
  logic [31:0]   dp_result;
  logic          dp_done;

  matvec_dot_scheduler #(.VLEN(VLEN), .ROWS(ROWS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix), .vector(vector),
    .busy(busy), .done(done), .error(error), .result(result),
    .row_idx(row_idx), .dp_A(dp_A), .dp_B(dp_B),
    .dp_result(dp_result), .dp_done(dp_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural engine ----------------
  logic [VW-1:0] eng_a, eng_b;
  logic [1:0]    eng_cnt;
  logic          eng_done;
  logic [31:0]   eng_res;
  logic          eng_stuck;

  function automatic logic [31:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    if (b == {F1, F1}) begin
      case (a)
        {F2, F1}: return F3;
        {F4, F3}: return F7;
        {F2, F2}: return F4;
        default:  return a[31:0] ^ a[63:32];
      endcase
    end
    return a[31:0] ^ b[31:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_a    <= '0;
      eng_b    <= '0;
      eng_cnt  <= 2'd3;
      eng_done <= 1'b1;
      eng_res  <= '0;
    end else if (dp_A != eng_a || dp_B != eng_b) begin
      eng_a    <= dp_A;
      eng_b    <= dp_B;
      eng_cnt  <= 2'd0;
      eng_done <= 1'b0;
    end else if (eng_cnt != 2'd3) begin
      eng_cnt <= eng_cnt + 2'd1;
      if (eng_cnt == 2'd2) begin
        eng_done <= 1'b1;
        eng_res  <= dot(eng_a, eng_b);
      end
    end
  end

  assign dp_done   = eng_stuck ? 1'b0 : eng_done;
  assign dp_result = eng_res;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [YW-1:0] res;
    int            cyc;
    logic          err;
    logic [RW-1:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int   bcnt;
    logic busy_prev;
    logic done_prev;
    exp_t e;
    bcnt      = 0;
    busy_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !busy_prev) bcnt = 1;
      else if (busy)          bcnt++;
      busy_prev = busy;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no job");
        end else begin
          e = exp_q.pop_front();
          chk("result",      128'(result),  128'(e.res));
          chk("busy_cycles", 128'(bcnt),    128'(e.cyc));
          chk("error",       128'(error),   128'(e.err));
          chk("row_idx_end", 128'(row_idx), 128'(e.row));
          chk("busy_at_done", 128'(busy),   128'(1'b0));
        end
      end
      done_prev = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [MW-1:0] m, input logic [VW-1:0] v);
    @(negedge clk);
    matrix = m;
    vector = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic expect_job(input logic [YW-1:0] r, input int cyc, input logic err,
                            input logic [RW-1:0] row);
    exp_t e;
    e.res = r;
    e.cyc = cyc;
    e.err = err;
    e.row = row;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done) return;
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_done: got done=0 expected done=1 within 300 cycles");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    128'(busy),    128'(0));
    chk({tag, "_done"},    128'(done),    128'(0));
    chk({tag, "_error"},   128'(error),   128'(0));
    chk({tag, "_result"},  128'(result),  128'(0));
    chk({tag, "_row_idx"}, 128'(row_idx), 128'(0));
    chk({tag, "_dp_A"},    128'(dp_A),    128'(0));
    chk({tag, "_dp_B"},    128'(dp_B),    128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    matrix    = '0;
    vector    = '0;
    eng_stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // basic job
    expect_job(Y1, 15, 1'b0, RW'(1));
    issue(M1, X1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("done_held", 128'(done), 128'(1));

    // duplicate second row: row 1 skips the engine wait
    expect_job(Y2, 10, 1'b0, RW'(1));
    issue(M2, X1);
    wait_done();

    // back-to-back identical basic jobs
    expect_job(Y1, 15, 1'b0, RW'(1));
    issue(M1, X1);
    wait_done();
    expect_job(Y1, 15, 1'b0, RW'(1));
    issue(M1, X1);
    wait_done();

    // row 0 equals the last operands left in the engine
    expect_job(Y3, 10, 1'b0, RW'(1));
    issue(M3, X1);
    wait_done();

    // start pulsed while busy is ignored; row 0 matches held operands
    expect_job(Y1, 10, 1'b0, RW'(1));
    issue(M1, X1);
    @(negedge clk);
    matrix = M2;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    matrix = M1;
    wait_done();
    repeat (5) @(negedge clk);
    chk("no_second_job_busy", 128'(busy), 128'(0));
    chk("no_second_job_done", 128'(done), 128'(1));

    // async reset during WAIT_DONE of row 1
    issue(M1, X1);
    repeat (11) @(negedge clk);
    chk("pre_reset_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk_all_zero("midjob_reset");
    @(negedge clk);
    rst = 1'b0;
    expect_job(Y1, 15, 1'b0, RW'(1));
    issue(M1, X1);
    wait_done();

`ifdef MVS_TIMEOUT_EN
    // engine never completes: watchdog aborts row 0
    eng_stuck = 1'b1;
    expect_job('0, 18, 1'b1, RW'(0));
    issue(M1, X1);
    wait_done();
    chk("timeout_error", 128'(error), 128'(1));
    eng_stuck = 1'b0;
`endif

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pending_expect: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
